logic_accum: RTL and testbench



---
 rtl/logic_accum_if.sv | 47 ++++
 rtl/logic_accum.sv | 142 ++++++++++++++
 tb/tb_logic_accum.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/logic_accum_if.sv
// ---------------------------------------------------------------------------
// logic_accum_if
// Bundles the flow-controlled operand and result channels of logic_accum.
//
// Signals (direction as seen by the logic unit, i.e. the slave):
//   in_valid   in   input beat present
//   in_ready   out  unit can accept a beat this cycle
//   op         in   00=AND, 01=OR, 10=XOR, 11=ANDN (A & ~in2)
//   acc_mode   in   1 = operand A comes from the internal accumulator
//   first      in   in acc_mode, this beat starts a new accumulation
//   in1        in   operand A (used unless accumulating with first=0)
//   in2        in   operand B
//   out_valid  out  out holds an unconsumed result
//   out_ready  in   consumer takes out this cycle
//   out        out  registered result
//   zero       out  registered flag, 1 when out == 0
//   beats      out  number of beats folded into out, saturating
// ---------------------------------------------------------------------------
interface logic_accum_if #(
  parameter int N     = 16,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic             acc_mode;
  logic             first;
  logic [N-1:0]     in1;
  logic [N-1:0]     in2;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out;
  logic             zero;
  logic [CNT_W-1:0] beats;

  // Producer/consumer side (drives operands, takes results).
  modport master (
    output in_valid, op, acc_mode, first, in1, in2, out_ready,
    input  in_ready, out_valid, out, zero, beats
  );

  // Logic unit side.
  modport slave (
    input  in_valid, op, acc_mode, first, in1, in2, out_ready,
    output in_ready, out_valid, out, zero, beats
  );
endinterface

// File: rtl/logic_accum.sv
// ---------------------------------------------------------------------------
// logic_accum
// Pipelined N-bit bitwise logic unit (AND / OR / XOR / ANDN) with a single
// registered output stage and valid/ready flow control on both sides.
// In accumulate mode operand A is taken from an internal register holding
// the previous result, so a stream of beats can be folded into one value
// (e.g. OR-reduce of a mask stream). A saturating counter reports how many
// beats contributed to the current result.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - logic_accum_if.slave: operand channel (in_*), op/mode controls
//          and result channel (out_*, zero, beats)
//
// Parameters:
//   N     - operand/result width in bits (>= 1)
//   CNT_W - width of the beat counter (>= 1)
// ---------------------------------------------------------------------------
module logic_accum #(
  parameter int N     = 16,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  logic_accum_if.slave  bus
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  localparam logic [CNT_W-1:0] BEATS_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] BEATS_MAX = '1;

  // Output register occupancy: the only control state in the unit.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     out_q,   out_d;
  logic [N-1:0]     acc_q,   acc_d;
  logic             zero_q,  zero_d;
  logic [CNT_W-1:0] beats_q, beats_d;

  logic             accept;
  logic             use_in1;
  logic [N-1:0]     operand_a;
  logic [N-1:0]     result;

  // -------------------------------------------------------------------------
  // Handshake. in_ready only looks at the output stage so there is no
  // combinational path from in_valid to in_ready; a consumer taking the
  // current result frees the stage in the same cycle (no bubble).
  // -------------------------------------------------------------------------
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.in_ready  = (state_q == ST_EMPTY) | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;

  // -------------------------------------------------------------------------
  // Operand select: a fresh operand is used outside accumulate mode and on
  // the first beat of an accumulation; otherwise the running value.
  // -------------------------------------------------------------------------
  assign use_in1   = ~bus.acc_mode | bus.first;
  assign operand_a = use_in1 ? bus.in1 : acc_q;

  // -------------------------------------------------------------------------
  // Bitwise datapath, one independent slice per bit.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign result[gi] = (bus.op == OP_AND) ? (operand_a[gi] &  bus.in2[gi]) :
                          (bus.op == OP_OR)  ? (operand_a[gi] |  bus.in2[gi]) :
                          (bus.op == OP_XOR) ? (operand_a[gi] ^  bus.in2[gi]) :
                                               (operand_a[gi] & ~bus.in2[gi]);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state logic. Every register holds by default; an accepted beat
  // reloads the whole output stage and the accumulator together.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    beats_d = beats_q;

    if (accept) begin
      out_d  = result;
      acc_d  = result;
      zero_d = (result == '0);
      if (use_in1) begin
        beats_d = BEATS_ONE;
      end else if (beats_q != BEATS_MAX) begin
        beats_d = beats_q + BEATS_ONE;
      end
    end

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // A new beat replaces a consumed result in the same cycle; without
        // one the stage drains once the consumer takes the result.
        if (!accept && bus.out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b1;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      beats_q <= beats_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.zero  = zero_q;
  assign bus.beats = beats_q;

endmodule

// File: tb/tb_logic_accum.sv
module tb_logic_accum;

  localparam int N     = 16;
  localparam int CNT_W = 2;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_ANDN = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic_accum_if #(.N(N), .CNT_W(CNT_W)) bus ();

  logic_accum #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0]     out;
    logic             zero;
    logic [CNT_W-1:0] beats;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until accepted; the expected result is
  // queued at the cycle the handshake completes.
  task automatic send(input logic [1:0] op, input logic am, input logic fs,
                      input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] eo, input logic [CNT_W-1:0] eb);
    exp_t e;
    bit   done;
    done         = 1'b0;
    bus.op       = op;
    bus.acc_mode = am;
    bus.first    = fs;
    bus.in1      = a;
    bus.in2      = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.out   = eo;
        e.zero  = (eo == '0);
        e.beats = eb;
        sb_q.push_back(e);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=0 for 50 cycles, required 1");
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    bus.in_valid  = 1'b0;
    bus.out_ready = ordy;
    for (int i = 0; i < n; i++) begin
      bus.in1 = bus.in1 ^ 16'h5A5A;
      bus.in2 = bus.in2 + 16'h1111;
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every consumed result is popped and compared.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: out=0x%04h with empty scoreboard, required none", bus.out);
      end else begin
        mon_e = sb_q.pop_front();
        txn++;
        $display("txn %0d out=0x%04h zero=%0b beats=%0d (exp 0x%04h %0b %0d)",
                 txn, bus.out, bus.zero, bus.beats, mon_e.out, mon_e.zero, mon_e.beats);
        chk($sformatf("txn%0d_out", txn),   32'(bus.out),   32'(mon_e.out));
        chk($sformatf("txn%0d_zero", txn),  32'(bus.zero),  32'(mon_e.zero));
        chk($sformatf("txn%0d_beats", txn), 32'(bus.beats), 32'(mon_e.beats));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = OP_AND;
    bus.acc_mode  = 1'b0;
    bus.first     = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;

    // Reset state while reset is held.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out",       32'(bus.out),       32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_zero",      32'(bus.zero),      32'h1);
    chk("rst_beats",     32'(bus.beats),     32'h0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Plain ops, back-to-back.
    send(OP_OR,   1'b0, 1'b0, 16'h00F0, 16'h0F01, 16'h0FF1, 2'd1);
    send(OP_AND,  1'b0, 1'b0, 16'hFF00, 16'h0FF0, 16'h0F00, 2'd1);
    send(OP_XOR,  1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 2'd1);
    send(OP_ANDN, 1'b0, 1'b0, 16'hFFFF, 16'h00FF, 16'hFF00, 2'd1);

    // OR accumulation; in1 is junk on non-first beats, idle gap before beat 3.
    send(OP_OR, 1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0003, 2'd1);
    send(OP_OR, 1'b1, 1'b0, 16'hDEAD, 16'h0100, 16'h0103, 2'd2);
    idle(3, 1'b1);
    send(OP_OR, 1'b1, 1'b0, 16'hBEEF, 16'h8000, 16'h8103, 2'd3);

    // Saturation of the 2-bit counter, mixing ops between beats.
    send(OP_XOR,  1'b1, 1'b1, 16'h0001, 16'h0010, 16'h0011, 2'd1);
    send(OP_XOR,  1'b1, 1'b0, 16'hFFFF, 16'h0100, 16'h0111, 2'd2);
    send(OP_XOR,  1'b1, 1'b0, 16'hFFFF, 16'h0011, 16'h0100, 2'd3);
    send(OP_AND,  1'b1, 1'b0, 16'h0000, 16'hFF00, 16'h0100, 2'd3);
    send(OP_ANDN, 1'b1, 1'b0, 16'hFFFF, 16'h0100, 16'h0000, 2'd3);

    // Backpressure: result held while inputs wiggle unaccepted.
    idle(1, 1'b1);
    bus.out_ready = 1'b0;
    send(OP_OR, 1'b0, 1'b0, 16'h1200, 16'h0034, 16'h1234, 2'd1);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = OP_XOR;
      bus.in1      = 16'h1111 * 16'(i + 1);
      bus.in2      = 16'hF0F0 >> i;
      @(negedge clk);
      chk($sformatf("bp%0d_in_ready", i),  32'(bus.in_ready),  32'h0);
      chk($sformatf("bp%0d_out", i),       32'(bus.out),       32'h1234);
      chk($sformatf("bp%0d_out_valid", i), 32'(bus.out_valid), 32'h1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(OP_OR, 1'b0, 1'b0, 16'h00AA, 16'h5500, 16'h55AA, 2'd1);
    chk("bp_no_bubble_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_no_bubble_out",   32'(bus.out),       32'h55AA);

    // Asynchronous reset mid-accumulation with a pending result.
    idle(1, 1'b1);
    bus.out_ready = 1'b0;
    send(OP_OR, 1'b1, 1'b1, 16'h00F0, 16'h000F, 16'h00FF, 2'd1);
    chk("pre_rst_out", 32'(bus.out), 32'h00FF);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out",       32'(bus.out),       32'h0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_zero",      32'(bus.zero),      32'h1);
    chk("arst_beats",     32'(bus.beats),     32'h0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'h1);
    #1;
    rst = 1'b0;
    sb_q.delete();
    bus.out_ready = 1'b1;
    send(OP_OR, 1'b1, 1'b0, 16'hFFFF, 16'h0010, 16'h0010, 2'd1);

    idle(3, 1'b1);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    chk("final_out_valid",    32'(bus.out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
